prog_clk_div: RTL and testbench
===============================

Name: prog_clk_div

Overview:
Programmable integer clock divider: the parametrised successor to the fixed ÷2/÷4/÷8 divider. It generates a 50%-duty output clock for any integer ratio N ≥ 2, even or odd. Ratio changes and stop requests take effect only at period boundaries, so the output never glitches. It also emits a one-cycle period strobe for logic that stays in the clk_in domain. It sits in the clock-generation area and feeds peripheral/baud clocks.

Parameters:
CNT_W, 8, width of ratio and period counter; max ratio 2^CNT_W-1
DEFAULT_DIV, 4, ratio loaded at reset; must be ≥2 and ≤2^CNT_W-1

Ports:
clk_in  input  1  source clock; all logic on posedge except one negedge flop (odd-ratio half-cycle stage)
rst  input  1  asynchronous, active-high reset
en  input  1  run request; 1 = divide, 0 = stop at next period boundary
cfg_valid  input  1  new ratio offered
cfg_div  input  CNT_W  new ratio N; values 0/1 are coerced to 2
cfg_ready  output  1  high when no ratio update is pending; transfer on cfg_valid&&cfg_ready
clk_out  output  1  divided clock, 50% duty (odd N: high N/2 clk_in periods via half-cycle stage)
period_tick  output  1  one clk_in-cycle pulse in the last cycle of each output period
cur_div  output  CNT_W  ratio currently in effect
running  output  1  high while the FSM is in RUN or DRAIN

Behaviour:
- Reset (async, any time, mid-period included): cnt=0, FSM=IDLE, cur_div=DEFAULT_DIV, no pending update, cfg_ready=1, clk_out=0 immediately (negedge flop cleared too), period_tick=0, running=0.
- Counter cnt runs 0..N-1 and wraps. A period boundary is the posedge on which cnt wraps N-1→0.
- Even N: clk_out high while cnt ∈ [0, N/2-1], low otherwise; output is registered, so the rising edge of clk_out coincides with the clk_in posedge on which cnt becomes 0.
- Odd N: pos_q is high for cnt ∈ [0,(N-1)/2]; neg_q is pos_q re-registered on negedge; clk_out = pos_q & neg_q. This gives a high time of exactly N/2 clk_in periods (e.g. 1.5 cycles for N=3).
- period_tick: registered, high exactly while cnt==N-1 in RUN or DRAIN.
- FSM:
  - IDLE: clk_out=0, cnt held 0. On en=1, go to RUN; the first period starts on the next posedge.
  - RUN: divide continuously. If en=0, go to DRAIN.
  - DRAIN: finish the current period. At the boundary, go to IDLE with clk_out=0. If en returns to 1 before the boundary, go back to RUN with no gap or glitch.
- Ratio update:
  - The accepted cfg_div is stored in a shadow register and cfg_ready drops.
  - In RUN/DRAIN, shadow is copied to cur_div at the next period boundary; cfg_ready rises 1 cycle later.
  - In IDLE, the copy happens on the next posedge.
  - Only one update can be pending; further offers stall.
- Simultaneous events:
  - Boundary and cfg accept on the same edge: the new ratio applies at the following boundary, not this one.
  - en falling and cfg accept together: the ratio is still applied at the drain boundary.
- N coercion: 0 and 1 become 2 at capture time. cur_div never holds a value below 2.

Decomposition:
- Package clk_div_pkg: FSM state enum (IDLE, RUN, DRAIN), constant MIN_DIV=2, and the coercion function (ratio → max(ratio, MIN_DIV)).
- Sub-module clk_div_core: counter, duty compare, negedge stage and tick. Inputs are cur_div and a run signal; it outputs the boundary flag to the top.
- The top holds the FSM, shadow register and handshake.

Test Plan:
- Reset release, en=1, DEFAULT_DIV=4 -> clk_out 2 high / 2 low, period_tick every 4th cycle, cur_div=4.
- cfg_div=3 accepted mid-period -> old ratio completes; then high time 1.5 cycles, period 3 cycles, 50% duty measured across both clk_in edges; cfg_ready returns 1 cycle after the boundary.
- cfg_div=1 and cfg_div=0 -> cur_div=2; clk_out = clk_in/2.
- en=0 at cnt=1 with N=6 -> clk_out completes its 6-cycle period, then stays 0; running=0. en re-raised at cnt=4 in DRAIN -> continuous output, no short pulse.
- Max ratio cfg_div=255 (CNT_W=8) -> high 127.5 cycles, period 255; counter wraps cleanly with no overflow.
- rst pulsed mid high phase -> clk_out=0 within the same cycle with no clock edge needed; cur_div=DEFAULT_DIV; back-to-back cfg_valid offers while one is pending are held off by cfg_ready=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the controller state encoding and ratio coercion.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] MIN_DIV = 32'd2;

    // Ratios below MIN_DIV cannot produce a two-phase clock, so they are raised to it.
    function automatic logic [31:0] coerce_div(input logic [31:0] ratio);
        logic [31:0] result;
        if (ratio < MIN_DIV) begin
            result = MIN_DIV;
        end else begin
            result = ratio;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter, duty compare, odd-ratio half-cycle stage and period strobe.
// Outputs are computed from the next count so edges line up with the count wrap.
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_boundary
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_hi_last;
    logic             r_started;
    logic             r_pos;
    logic             r_neg;
    logic             r_tick;
    logic             w_wrap;

    // Next count and the last count of the high phase for the current ratio.
    always_comb begin
        w_last    = i_div - ONE;
        w_hi_last = {1'b0, w_last[CNT_W-1:1]};
        w_wrap    = r_started && (r_cnt >= w_last);
        if (w_wrap) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + ONE;
        end
    end

    // First run edge opens a period at count 0; a stop request closes it at the wrap.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_pos     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!i_run) begin
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_pos     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!r_started) begin
            r_cnt     <= '0;
            r_started <= 1'b1;
            r_pos     <= 1'b1;
            r_tick    <= 1'b0;
        end else if (w_wrap && i_stop) begin
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_pos     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pos     <= (w_cnt_nxt <= w_hi_last);
            r_tick    <= (w_cnt_nxt == w_last);
        end
    end

    // Half-cycle delayed copy trims odd-ratio high time by half a source period.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= r_pos;
        end
    end

    assign o_clk      = r_pos & (r_neg | ~i_div[0]);
    assign o_tick     = r_tick;
    assign o_boundary = i_run && w_wrap;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable integer clock divider: run/stop controller, ratio shadow and handshake.
// Ratio changes and stops only take effect at period boundaries.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             period_tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_running;
    logic             r_pend;
    logic             r_copied;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] w_cfg_coerced;
    logic             w_run;
    logic             w_stop;
    logic             w_boundary;
    logic             w_accept;
    logic             w_copy;

    // Controller next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (en) begin
                    w_state_nxt = RUN;
                end else if (w_boundary) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run         = (r_state == RUN) || (r_state == DRAIN);
    assign w_stop        = (r_state == DRAIN) && !en;
    assign w_accept      = cfg_valid && !r_pend;
    assign w_copy        = r_pend && !r_copied && ((r_state == IDLE) || w_boundary);
    assign w_cfg_coerced = CNT_W'(coerce_div(32'(cfg_div)));

    // State register and registered run indication.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
        end
    end

    // Pending flag stays up one extra cycle after the copy so ready rises after the boundary.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_copied  <= 1'b0;
            r_shadow  <= DIV_RST;
            r_cur_div <= DIV_RST;
        end else begin
            r_copied <= w_copy;
            if (w_accept) begin
                r_shadow <= w_cfg_coerced;
                r_pend   <= 1'b1;
            end else if (r_copied) begin
                r_pend <= 1'b0;
            end
            if (w_copy) begin
                r_cur_div <= r_shadow;
            end
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in     (clk_in),
        .rst        (rst),
        .i_run      (w_run),
        .i_stop     (w_stop),
        .i_div      (r_cur_div),
        .o_clk      (clk_out),
        .o_tick     (period_tick),
        .o_boundary (w_boundary)
    );

    assign cfg_ready = ~r_pend;
    assign cur_div   = r_cur_div;
    assign running   = r_running;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: period-position model plus directed literal checks.
module tb_prog_clk_div;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             period_tick;
    logic [CNT_W-1:0] cur_div;
    logic             running;

    int n_cmp = 0;
    int n_err = 0;

    prog_clk_div #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .cur_div     (cur_div),
        .running     (running)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle / 1 run / 2 drain; ph = position within the current period, -1 if none.
    int m_mode = 0, m_ph = -1, m_div = DEF, m_shadow = DEF, m_cyc = 0, m_release = 0;
    bit m_pend = 1'b0;

    function automatic int m_ready();
        return (!m_pend && (m_cyc >= m_release)) ? 1 : 0;
    endfunction

    function automatic int exp_clk(input bit at_pos);
        int half;
        if (m_ph < 0) return 0;
        half = (m_div - 1) / 2;
        if (m_div % 2 == 0) return (m_ph <= half) ? 1 : 0;
        if (at_pos) return (m_ph >= 1 && m_ph <= half) ? 1 : 0;
        return (m_ph <= half) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = -1; m_div = DEF; m_shadow = DEF;
        m_pend = 1'b0; m_cyc = 0; m_release = 0;
    endtask

    task automatic model_step();
        int  v;
        bit  acc, bnd, cp;
        acc = cfg_valid && (m_ready() == 1);
        bnd = (m_mode != 0) && (m_ph == m_div - 1);
        cp  = m_pend && (m_mode == 0 || bnd);
        m_cyc++;
        if (m_mode == 0)                     m_ph = -1;
        else if (m_ph < 0)                   m_ph = 0;
        else if (bnd && m_mode == 2 && !en)  m_ph = -1;
        else if (bnd)                        m_ph = 0;
        else                                 m_ph = m_ph + 1;
        if (m_mode == 0)      m_mode = en ? 1 : 0;
        else if (m_mode == 1) m_mode = en ? 1 : 2;
        else                  m_mode = en ? 1 : (bnd ? 0 : 2);
        if (cp) begin
            m_div = m_shadow; m_pend = 1'b0; m_release = m_cyc + 1;
        end
        if (acc) begin
            v = int'(cfg_div);
            m_shadow = (v < 2) ? 2 : v;
            m_pend = 1'b1;
        end
    endtask

    // Single compare process: model advances on posedge, outputs checked after both edges.
    always begin
        @(posedge clk_in);
        if (rst) model_reset(); else model_step();
        #1;
        if (!rst) begin
            check("clk_out_pos", int'(clk_out), exp_clk(1'b1));
            check("period_tick", int'(period_tick), (m_ph >= 0 && m_ph == m_div - 1) ? 1 : 0);
            check("cur_div", int'(cur_div), m_div);
            check("running", int'(running), (m_mode != 0) ? 1 : 0);
            check("cfg_ready", int'(cfg_ready), m_ready());
        end
        @(negedge clk_in);
        #1;
        if (!rst) check("clk_out_neg", int'(clk_out), exp_clk(1'b0));
    end

    // Half-cycle run lengths of clk_out, used for literal duty checks.
    int   run_len = 0, hi_len = 0, lo_len = 0;
    logic prev_clk = 1'b0;
    always begin
        @(clk_in);
        #1;
        if (rst) begin
            run_len = 0; prev_clk = 1'b0;
        end else if (clk_out === prev_clk) begin
            run_len++;
        end else begin
            if (prev_clk) hi_len = run_len; else lo_len = run_len;
            run_len = 1; prev_clk = clk_out;
        end
    end

    // Cycles between period strobes.
    int since_tick = 0, tick_gap = 0;
    always begin
        @(posedge clk_in);
        #1;
        since_tick++;
        if (period_tick) begin
            tick_gap = since_tick; since_tick = 0;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #3;
        end
    endtask

    task automatic offer(input int v);
        bit done;
        done = 1'b0;
        cfg_valid = 1'b1;
        cfg_div = v[CNT_W-1:0];
        for (int i = 0; i < 600 && !done; i++) begin
            if (cfg_ready) done = 1'b1;
            step(1);
        end
        cfg_valid = 1'b0;
        if (!done) check("offer_timeout", 0, 1);
    endtask

    task automatic wait_tick(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (period_tick) seen = 1'b1;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    task automatic check_shape(input string tag, input int n);
        check({tag, "_hi_halves"}, hi_len, n);
        check({tag, "_lo_halves"}, lo_len, n);
        check({tag, "_tick_gap"}, tick_gap, n);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step(3);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_cur_div", int'(cur_div), 4);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_running", int'(running), 0);
        check("rst_tick", int'(period_tick), 0);
        rst = 1'b0;
        step(2);

        // Default ratio 4: start latency and shape.
        en = 1'b1;
        step(1);
        check("start_running", int'(running), 1);
        check("start_clk_low", int'(clk_out), 0);
        step(1);
        check("first_rise", int'(clk_out), 1);
        step(3);
        check("first_tick", int'(period_tick), 1);
        step(20);
        check_shape("div4", 8 / 2);

        // Ratio 3 offered mid-period.
        step(1);
        offer(3);
        check("pending_ready_low", int'(cfg_ready), 0);
        step(20);
        check("div3_cur", int'(cur_div), 3);
        check_shape("div3", 3);

        // Coercion of 1 and 0.
        offer(1);
        step(16);
        check("div1_cur", int'(cur_div), 2);
        check_shape("div1", 2);
        offer(5);
        step(20);
        offer(0);
        step(20);
        check("div0_cur", int'(cur_div), 2);
        check_shape("div0", 2);

        // Drain with ratio 6: en dropped at count 1.
        offer(6);
        step(20);
        wait_tick(20);
        step(2);
        en = 1'b0;
        step(15);
        check("drain_running", int'(running), 0);
        check("drain_clk", int'(clk_out), 0);
        check("drain_last_hi", hi_len, 6);

        // Drain cancelled at count 4: continuous output.
        en = 1'b1;
        wait_tick(20);
        step(2);
        en = 1'b0;
        step(3);
        check("cancel_running", int'(running), 1);
        en = 1'b1;
        step(30);
        check_shape("div6", 6);

        // Maximum ratio.
        offer(255);
        step(800);
        check("div255_cur", int'(cur_div), 255);
        check_shape("div255", 255);

        // Back-to-back offers while one is pending.
        offer(5);
        cfg_valid = 1'b1; cfg_div = 8'd8;
        step(1);
        check("b2b_held", int'(cfg_ready), 0);
        offer(8);
        step(30);
        check("b2b_cur", int'(cur_div), 8);

        // Asynchronous reset in the high phase.
        begin
            bit hi_seen;
            hi_seen = 1'b0;
            for (int i = 0; i < 40 && !hi_seen; i++) begin
                step(1);
                if (clk_out) hi_seen = 1'b1;
            end
            if (!hi_seen) check("high_timeout", 0, 1);
        end
        rst = 1'b1;
        #1;
        check("async_rst_clk", int'(clk_out), 0);
        check("async_rst_cur", int'(cur_div), 4);
        check("async_rst_ready", int'(cfg_ready), 1);
        check("async_rst_running", int'(running), 0);
        step(2);
        rst = 1'b0;
        step(25);
        check("post_rst_cur", int'(cur_div), 4);
        check_shape("post_rst", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
